// File: rtl/dac_spi_out.sv
// dac_spi_out: SPI master serialising one word per request to a MAX5134 DAC.
// The word is {8-bit command, 16-bit sample}, MSB first, CPOL=0. The DAC
// samples on the SCLK falling edge.
//
// Ports:
//   clock_in      - system clock, rising edge
//   reset         - asynchronous, active-high reset
//   data_in       - word to send, captured when a request is accepted
//   send          - request strobe, honoured only while idle
//   spi_cs_out    - active-low chip select
//   spi_clock_out - serial clock, idles low
//   spi_data_out  - serial data, MSB first
//   busy          - high during a transfer and the post-transfer CS-high gap
module dac_spi_out #(
  parameter int unsigned WORD_BITS   = 24,
  parameter int unsigned HALF_PERIOD = 2,
  parameter int unsigned GAP_CYCLES  = 4
) (
  input  logic                 clock_in,
  input  logic                 reset,
  input  logic [WORD_BITS-1:0] data_in,
  input  logic                 send,
  output logic                 spi_cs_out,
  output logic                 spi_clock_out,
  output logic                 spi_data_out,
  output logic                 busy
);

  // One shared timing counter covers both the half-period and the gap.
  localparam int unsigned CNT_MAX = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned BIT_W   = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;

  localparam logic [CNT_W-1:0] HP_LAST  = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_e;

  state_e               state_q, state_d;
  logic [WORD_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic [BIT_W-1:0]     bit_q,   bit_d;
  logic                 cs_q,    cs_d;
  logic                 sclk_q,  sclk_d;
  logic                 data_q,  data_d;
  logic                 busy_q,  busy_d;

  // State and output registers; reset aborts any transfer with CS high.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      data_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    data_d  = data_q;
    busy_d  = busy_q;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (send) begin
          shift_d = data_in;
          cs_d    = 1'b0;
          data_d  = data_in[WORD_BITS-1];
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end
      end

      // CS-to-first-SCLK lead time; the first rising edge leaves this state.
      S_SETUP: begin
        if (cnt_q == HP_LAST) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          data_d  = shift_q[WORD_BITS-1];
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // sclk_q itself marks which half of the bit period is running.
      // Data only changes together with a rising edge, so it is stable
      // a full half-period either side of the falling (sampling) edge.
      S_SHIFT: begin
        if (cnt_q != HP_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
          end else if (bit_q == BIT_LAST) begin
            state_d = S_HOLD;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = {shift_q[WORD_BITS-2:0], 1'b0};
            data_d  = shift_q[WORD_BITS-2];
            sclk_d  = 1'b1;
          end
        end
      end

      // Last low half-period has elapsed; keep CS low one more half-period.
      S_HOLD: begin
        if (cnt_q == HP_LAST) begin
          cnt_d   = '0;
          cs_d    = 1'b1;
          data_d  = 1'b0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign spi_cs_out    = cs_q;
  assign spi_clock_out = sclk_q;
  assign spi_data_out  = data_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_dac_spi_out.sv
// tb_dac_spi_out: scoreboard bench for dac_spi_out at default parameters.
// Stimulus pushes each expected DAC word; a monitor rebuilds frames from the
// SPI pins (bits taken on SCLK falling edges) and checks them against the queue.
module tb_dac_spi_out;

  localparam int unsigned W          = 24;
  localparam int          CS_LOW_LEN = 100;  // 2 * (2*24 + 2)
  localparam int          BUSY_DROP  = 4;    // clocks from CS rise to busy fall
  localparam int          GAP_MIN    = 4;
  localparam int          BUDGET     = 1000;

  logic         clock_in = 1'b0;
  logic         reset;
  logic [W-1:0] data_in;
  logic         send;
  logic         spi_cs_out;
  logic         spi_clock_out;
  logic         spi_data_out;
  logic         busy;

  dac_spi_out dut (
    .clock_in      (clock_in),
    .reset         (reset),
    .data_in       (data_in),
    .send          (send),
    .spi_cs_out    (spi_cs_out),
    .spi_clock_out (spi_clock_out),
    .spi_data_out  (spi_data_out),
    .busy          (busy)
  );

  always #5 clock_in = ~clock_in;

  int           n_pass   = 0;
  int           n_total  = 0;
  int           n_pushed = 0;
  int           n_frames = 0;
  int           n_stray  = 0;
  logic [W-1:0] sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic expect_word(input logic [W-1:0] w);
    sb.push_back(w);
    n_pushed++;
  endtask

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic pulse_send(input logic [W-1:0] w);
    data_in = w;
    send    = 1'b1;
    tick();
    send    = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy !== 1'b0 && t < BUDGET) begin
      tick();
      t++;
    end
    check("idle_timeout", 32'(t < BUDGET), 32'd1);
  endtask

  // Waits for the next accepted request (busy low, then high).
  task automatic wait_accept();
    int t = 0;
    while (busy !== 1'b0 && t < BUDGET) begin
      tick();
      t++;
    end
    while (busy !== 1'b1 && t < BUDGET) begin
      tick();
      t++;
    end
    check("accept_timeout", 32'(t < BUDGET), 32'd1);
  endtask

  // Monitor: samples pins on the falling system-clock edge.
  logic         prev_cs   = 1'b1;
  logic         prev_sclk = 1'b0;
  logic [W-1:0] mon_word  = '0;
  int           nbits = 0, nrise = 0, cs_len = 0, gap_len = 0, busy_cnt = 0;
  bit           have_prev = 1'b0, busy_track = 1'b0;

  always @(negedge clock_in) begin
    if (reset) begin
      prev_cs    = 1'b1;
      prev_sclk  = 1'b0;
      nbits      = 0;
      nrise      = 0;
      have_prev  = 1'b0;
      busy_track = 1'b0;
    end else begin
      if (prev_cs && !spi_cs_out) begin
        if (have_prev) check("cs_gap_min", 32'(gap_len >= GAP_MIN), 32'd1);
        nbits    = 0;
        nrise    = 0;
        cs_len   = 0;
        mon_word = '0;
      end
      if (!spi_cs_out) cs_len++;
      else gap_len++;
      if (spi_cs_out && (spi_clock_out != prev_sclk)) n_stray++;
      if (!prev_sclk && spi_clock_out) nrise++;
      if (prev_sclk && !spi_clock_out) begin
        mon_word = {mon_word[W-2:0], spi_data_out};
        nbits++;
      end
      if (!prev_cs && spi_cs_out) begin
        n_frames++;
        check("frame_bits", 32'(nbits), 32'd24);
        check("frame_rises", 32'(nrise), 32'd24);
        check("cs_low_len", 32'(cs_len), 32'(CS_LOW_LEN));
        check("frame_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) check("frame_word", 32'(mon_word), 32'(sb.pop_front()));
        gap_len    = 1;
        have_prev  = 1'b1;
        busy_track = 1'b1;
        busy_cnt   = 0;
      end
      if (busy_track) begin
        if (busy) busy_cnt++;
        else begin
          check("busy_drop", 32'(busy_cnt), 32'(BUSY_DROP));
          busy_track = 1'b0;
        end
      end
      prev_cs   = spi_cs_out;
      prev_sclk = spi_clock_out;
    end
  end

  // Stimulus.
  initial begin
    logic [W-1:0] b2b [4];
    int           nfall;
    int           t;
    logic         ps;

    b2b[0] = 24'hFFFFFF;
    b2b[1] = 24'h000000;
    b2b[2] = 24'hFFFFFF;
    b2b[3] = 24'h000000;

    reset   = 1'b1;
    send    = 1'b0;
    data_in = '0;
    repeat (3) @(posedge clock_in);
    #1;
    check("reset_outputs", 32'({spi_cs_out, spi_clock_out, spi_data_out, busy}), 32'b1000);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_outputs", 32'({spi_cs_out, spi_clock_out, spi_data_out, busy}), 32'b1000);
    end

    // Single word; data_in is scrambled right after acceptance.
    expect_word(24'h31ABCD);
    pulse_send(24'h31ABCD);
    check("accept_cs", 32'(spi_cs_out), 32'd0);
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_msb", 32'(spi_data_out), 32'd0);
    data_in = 24'h000000;
    wait_idle();
    repeat (5) tick();

    // A send pulse 30 clocks into a transfer must be dropped.
    expect_word(24'h310000);
    pulse_send(24'h310000);
    repeat (28) tick();
    check("busy_mid_xfer", 32'(busy), 32'd1);
    pulse_send(24'hAAAAAA);
    wait_idle();
    repeat (3) tick();
    expect_word(24'h31AAAA);
    pulse_send(24'h31AAAA);
    wait_idle();
    repeat (3) tick();

    // Back-to-back with send held high.
    send = 1'b1;
    for (int k = 0; k < 4; k++) begin
      data_in = b2b[k];
      expect_word(b2b[k]);
      wait_accept();
    end
    send = 1'b0;
    wait_idle();
    repeat (3) tick();

    // Reset after the 10th falling SCLK edge aborts the frame.
    pulse_send(24'h31F0F0);
    nfall = 0;
    t     = 0;
    ps    = spi_clock_out;
    while (nfall < 10 && t < BUDGET) begin
      tick();
      t++;
      if (ps && !spi_clock_out) nfall++;
      ps = spi_clock_out;
    end
    check("fall_timeout", 32'(t < BUDGET), 32'd1);
    check("pre_abort_cs", 32'(spi_cs_out), 32'd0);
    reset = 1'b1;
    #1;
    check("abort_outputs", 32'({spi_cs_out, spi_clock_out, spi_data_out, busy}), 32'b1000);
    repeat (3) @(posedge clock_in);
    #1;
    reset = 1'b0;
    tick();
    expect_word(24'h315555);
    pulse_send(24'h315555);
    wait_idle();
    repeat (10) tick();

    check("sb_empty", 32'(sb.size()), 32'd0);
    check("frame_count", 32'(n_frames), 32'(n_pushed));
    check("stray_sclk", 32'(n_stray), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
